calc_sequencer: RTL and testbench

- Multi-cycle controller wrapped around the calculator arithmetic datapath (add, subtract-with-sign, multiply, divide-with-remainder).
- Accepts one operation at a time from the keypad/UI front end through a start/ready handshake.
- Runs add/sub/mul in one execute cycle and division as a 32-cycle restoring shift-subtract sequence.
- Holds result, remainder and status flags stable for the display logic until the next operation completes.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/calc_div_step.sv | 43 ++++
 rtl/calc_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator sequencer:
//   - operation codes presented on the op input
//   - controller state encoding
//   - default display overflow limit and division step count
//   - helper that decides whether a full-precision result is too large to show
// -----------------------------------------------------------------------------
package calc_pkg;

    // Operation codes as driven by the keypad/UI front end.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DIV  = 2'b10
    } state_e;

    // Largest value the display can show.
    localparam logic [31:0] OVF_LIMIT_DEFAULT = 32'h0000FFFF;

    // One restoring iteration per operand bit.
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned DIV_CNT_W = 5;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_STEPS - 1);

    // True when a full-precision result cannot be shown on the display.
    function automatic logic exceeds_limit(input logic [63:0] value,
                                           input logic [31:0] limit);
        return (value > {32'h0000_0000, limit});
    endfunction

endpackage : calc_pkg

// File: rtl/calc_div_step.sv
// -----------------------------------------------------------------------------
// calc_div_step
// One combinational restoring-division iteration.
//   rem_i     [32:0]  partial remainder before the step
//   quo_i     [31:0]  dividend/quotient shift register before the step
//   divisor_i [31:0]  divisor
//   rem_o     [32:0]  partial remainder after the step
//   quo_o     [31:0]  quotient shift register after the step
// The pair {rem, quo} is shifted left by one; the dividend bit that leaves the
// top of quo enters the bottom of rem. If the shifted remainder is at least the
// divisor, the divisor is subtracted and a 1 is shifted into the quotient.
// -----------------------------------------------------------------------------
module calc_div_step
    import calc_pkg::*;
(
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    // Shifted remainder is kept one bit wider than the stored remainder so the
    // comparison stays exact for divisors of 2^31 and above.
    logic [33:0] shifted_rem_s;
    logic [31:0] shifted_quo_s;
    logic [33:0] divisor_ext_s;

    // Shift, trial-compare and conditionally subtract.
    always_comb begin
        shifted_rem_s = {rem_i, quo_i[31]};
        shifted_quo_s = {quo_i[30:0], 1'b0};
        divisor_ext_s = {2'b00, divisor_i};
        if (shifted_rem_s >= divisor_ext_s) begin
            rem_o = 33'(shifted_rem_s - divisor_ext_s);
            quo_o = shifted_quo_s | 32'h0000_0001;
        end else begin
            rem_o = 33'(shifted_rem_s);
            quo_o = shifted_quo_s;
        end
    end

endmodule : calc_div_step

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Multi-cycle controller around the calculator arithmetic datapath.
//   clk       in        system clock, rising edge
//   rst_n     in        asynchronous active-low reset
//   start     in        operation request, accepted only while ready
//   op        in  [1:0] 00 add, 01 sub, 10 mul, 11 div
//   operand1  in  [31:0] first operand / dividend
//   operand2  in  [31:0] second operand / divisor
//   ready     out       idle, a new start can be accepted
//   busy      out       inverse of ready
//   done      out       one-cycle pulse when the outputs below update
//   result    out [31:0] sum, |difference|, low product word or quotient
//   mod       out [31:0] remainder for div, otherwise 0
//   negative  out       sub with operand1 < operand2
//   overflow  out       add/mul full-precision result above OVF_LIMIT
//   error     out       div by zero
// Add, sub, mul and divide-by-zero complete one cycle after acceptance;
// a valid division takes DIV_STEPS cycles. Results hold until the next
// completion and are not cleared when a new operation starts.
// -----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
#(
    parameter logic [31:0] OVF_LIMIT = OVF_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mod,
    output logic        negative,
    output logic        overflow,
    output logic        error
);

    // Control state and latched operation.
    state_e                 state_q,    state_d;
    op_e                    op_q,       op_d;
    logic [31:0]            a_q,        a_d;
    logic [31:0]            b_q,        b_d;

    // Division working registers.
    logic [32:0]            rem_q,      rem_d;
    logic [31:0]            quo_q,      quo_d;
    logic [DIV_CNT_W-1:0]   cnt_q,      cnt_d;

    // Registered display outputs.
    logic                   done_q,     done_d;
    logic [31:0]            result_q,   result_d;
    logic [31:0]            mod_q,      mod_d;
    logic                   negative_q, negative_d;
    logic                   overflow_q, overflow_d;
    logic                   error_q,    error_d;

    // Single-cycle datapath results.
    logic [32:0]            sum_s;
    logic [63:0]            prod_s;
    logic [32:0]            step_rem_s;
    logic [31:0]            step_quo_s;

    calc_div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (b_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

    // Full-precision add and multiply of the latched operands.
    always_comb begin
        sum_s  = {1'b0, a_q} + {1'b0, b_q};
        prod_s = {32'h0000_0000, a_q} * {32'h0000_0000, b_q};
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        result_d   = result_q;
        mod_d      = mod_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op_e'(op);
                    a_d   = operand1;
                    b_d   = operand2;
                    // Division starts with an empty remainder and the
                    // dividend in the quotient shift register.
                    rem_d = 33'd0;
                    quo_d = operand1;
                    cnt_d = {DIV_CNT_W{1'b0}};
                    // Divide-by-zero is resolved in one cycle like add/sub/mul.
                    if ((op == OP_DIV) && (operand2 != 32'd0)) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                done_d     = 1'b1;
                state_d    = ST_IDLE;
                mod_d      = 32'd0;
                negative_d = 1'b0;
                overflow_d = 1'b0;
                error_d    = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        result_d   = sum_s[31:0];
                        overflow_d = exceeds_limit({31'd0, sum_s}, OVF_LIMIT);
                    end
                    OP_SUB: begin
                        if (a_q >= b_q) begin
                            result_d   = a_q - b_q;
                            negative_d = 1'b0;
                        end else begin
                            result_d   = b_q - a_q;
                            negative_d = 1'b1;
                        end
                    end
                    OP_MUL: begin
                        result_d   = prod_s[31:0];
                        overflow_d = exceeds_limit(prod_s, OVF_LIMIT);
                    end
                    OP_DIV: begin
                        // Only a zero divisor reaches EXEC with a division.
                        result_d = 32'd0;
                        error_d  = 1'b1;
                    end
                    default: begin
                        result_d = 32'd0;
                    end
                endcase
            end

            ST_DIV: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == DIV_LAST) begin
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                    result_d   = step_quo_s;
                    // Final remainder is below the divisor, so bit 32 is zero.
                    mod_d      = step_rem_s[31:0];
                    negative_d = 1'b0;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end else begin
                    state_d = ST_DIV;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            cnt_q      <= {DIV_CNT_W{1'b0}};
            done_q     <= 1'b0;
            result_q   <= 32'd0;
            mod_q      <= 32'd0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            mod_q      <= mod_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    // Handshake status comes straight from the state register.
    assign ready    = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign mod      = mod_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule : calc_sequencer

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
// Self-checking bench: a latency-counting behavioural model computes every
// result with plain arithmetic, a compare process checks all outputs against
// it on every falling edge, and directed operations pin literal expectations.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic        ready, busy, done, negative, overflow, error;
    logic [31:0] result, mod;

    calc_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mod      (mod),
        .negative (negative),
        .overflow (overflow),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] md;
        logic        ng;
        logic        ov;
        logic        er;
    } res_t;

    function automatic res_t calc_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t        x;
        logic [32:0] s;
        logic [63:0] p;
        x = '0;
        case (o)
            2'd0: begin
                s    = {1'b0, a} + {1'b0, b};
                x.r  = s[31:0];
                x.ov = (s > 33'h0_0000_FFFF);
            end
            2'd1: begin
                if (a >= b) begin x.r = a - b; x.ng = 1'b0; end
                else        begin x.r = b - a; x.ng = 1'b1; end
            end
            2'd2: begin
                p    = {32'd0, a} * {32'd0, b};
                x.r  = p[31:0];
                x.ov = (p > 64'h0000_0000_0000_FFFF);
            end
            default: begin
                if (b == 32'd0) x.er = 1'b1;
                else begin x.r = a / b; x.md = a % b; end
            end
        endcase
        return x;
    endfunction

    logic m_ready = 1'b1;
    logic m_done  = 1'b0;
    int   m_left  = 0;
    res_t m_pend  = '0;
    res_t m_vis   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_left  <= 0;
            m_pend  <= '0;
            m_vis   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_ready) begin
                if (start) begin
                    m_pend  <= calc_model(op, operand1, operand2);
                    m_left  <= ((op == 2'd3) && (operand2 != 32'd0)) ? 32 : 1;
                    m_ready <= 1'b0;
                end
            end else begin
                if (m_left == 1) begin
                    m_vis   <= m_pend;
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",    {31'd0, ready},    {31'd0, m_ready});
            chk("busy",     {31'd0, busy},     {31'd0, ~m_ready});
            chk("done",     {31'd0, done},     {31'd0, m_done});
            chk("result",   result,            m_vis.r);
            chk("mod",      mod,               m_vis.md);
            chk("negative", {31'd0, negative}, {31'd0, m_vis.ng});
            chk("overflow", {31'd0, overflow}, {31'd0, m_vis.ov});
            chk("error",    {31'd0, error},    {31'd0, m_vis.er});
        end
    end

    // ---------------- directed operation with literal expectations ----------
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] em,
                         input logic en, input logic eo, input logic ee,
                         input int elat, input int ign_at);
        int   lat;
        logic got;
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        @(negedge clk);
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        lat = 0;
        got = 1'b0;
        while ((lat < 100) && !got) begin
            if (lat == ign_at) begin
                start    = 1'b1;
                op       = 2'd0;
                operand1 = 32'h1111_1111;
                operand2 = 32'h0000_0001;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) got = 1'b1;
            else chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        end
        chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_result"}, result, er);
        chk({nm, "_mod"}, mod, em);
        chk({nm, "_negative"}, {31'd0, negative}, {31'd0, en});
        chk({nm, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({nm, "_error"}, {31'd0, error}, {31'd0, ee});
        chk({nm, "_ready_in_done"}, {31'd0, ready}, 32'd1);
    endtask

    function automatic logic [31:0] gen_operand();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return $urandom_range(0, 300);
            2:       return 32'd0;
            3:       return 32'd1;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom_range(0, 70000);
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready",  {31'd0, ready}, 32'd1);
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add_small", 2'd0, 32'h1234, 32'h1, 32'h1235, 32'd0, 1'b0, 1'b0, 1'b0, 1, -1);
        do_op("add_ovf",   2'd0, 32'hFFFF, 32'h1, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1, -1);
        do_op("mul_ovf",   2'd2, 32'h100, 32'h100, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1, -1);
        do_op("mul_ok",    2'd2, 32'hFF, 32'hFF, 32'h0000_FE01, 32'd0, 1'b0, 1'b0, 1'b0, 1, -1);
        do_op("div_100_7", 2'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 32, 10);
        do_op("sub_neg",   2'd1, 32'd5, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, 1, -1);
        do_op("sub_eq",    2'd1, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1, -1);
        do_op("div_big",   2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 1'b0, 1'b0, 32, -1);
        do_op("div_zero",  2'd3, 32'd12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1, -1);
        do_op("add_wrap",  2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1, -1);
        do_op("div_0_x",   2'd3, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32, -1);
        do_op("div_x_1",   2'd3, 32'd77, 32'd1, 32'd77, 32'd0, 1'b0, 1'b0, 1'b0, 32, -1);

        // Reset in the middle of a division.
        start    = 1'b1;
        op       = 2'd3;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_result", result,         32'd0);
        chk("midrst_mod",    mod,            32'd0);
        chk("midrst_ready",  {31'd0, ready}, 32'd1);
        chk("midrst_busy",   {31'd0, busy},  32'd0);
        chk("midrst_done",   {31'd0, done},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        do_op("add_after_rst", 2'd0, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1, -1);

        // Randomized traffic, including starts while busy.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 2) == 0);
            op       = 2'($urandom);
            operand1 = gen_operand();
            operand2 = gen_operand();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_calc_sequencer
